// File: rtl/axi_mem_pkg.sv
// ============================================================================
// Module : axi_mem_pkg
// Brief  : Shared constants, state encodings and helpers for axi_mem_slave.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package axi_mem_pkg;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;
    localparam int ID_W   = 4;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [2:0] SIZE_16B = 3'b100;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } wr_state_t;

    // Response codes are ordered so that the numerically larger one is worse.
    function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                     input logic [1:0]        burst);
        return (burst == BURST_FIXED) ? addr : addr + ADDR_W'(16);
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_mem_ram.sv
// ============================================================================
// Module : axi_mem_ram
// Brief  : Word-wide RAM, one synchronous read port, one byte-enabled write port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module axi_mem_ram
    import axi_mem_pkg::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [DATA_W-1:0]    rd_data,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic [STRB_W-1:0]    wr_strb
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [DATA_W-1:0] mem [DEPTH];

    // Read and write share an edge, so a same-word collision returns old data.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/axi_mem_slave.sv
// ============================================================================
// Module : axi_mem_slave
// Brief  : AXI4 memory slave, independent read/write FSMs over axi_mem_ram.
//          Define AXI_MEM_SLAVE_STALL_EN to enable LFSR-driven backpressure.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module axi_mem_slave
    import axi_mem_pkg::*;
#(
    parameter int MEM_DEPTH_LOG2 = 10
) (
    input  logic              clk,
    input  logic              aresetn,

    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic [1:0]        s_axi_arburst,
    input  logic [3:0]        s_axi_arcache,
    input  logic [ID_W-1:0]   s_axi_arid,
    input  logic [7:0]        s_axi_arlen,
    input  logic              s_axi_arlock,
    input  logic [2:0]        s_axi_arprot,
    input  logic [3:0]        s_axi_arqos,
    input  logic [2:0]        s_axi_arsize,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,

    output logic [DATA_W-1:0] s_axi_rdata,
    output logic [ID_W-1:0]   s_axi_rid,
    output logic              s_axi_rlast,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,

    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic [1:0]        s_axi_awburst,
    input  logic [3:0]        s_axi_awcache,
    input  logic [ID_W-1:0]   s_axi_awid,
    input  logic [7:0]        s_axi_awlen,
    input  logic              s_axi_awlock,
    input  logic [2:0]        s_axi_awprot,
    input  logic [3:0]        s_axi_awqos,
    input  logic [2:0]        s_axi_awsize,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,

    input  logic [DATA_W-1:0] s_axi_wdata,
    input  logic [STRB_W-1:0] s_axi_wstrb,
    input  logic              s_axi_wlast,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,

    output logic [ID_W-1:0]   s_axi_bid,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready
);

    function automatic logic [1:0] beat_resp(input logic [ADDR_W-1:0] addr,
                                             input logic [1:0]        burst,
                                             input logic [2:0]        size);
        if ((addr >> (MEM_DEPTH_LOG2 + 4)) != '0) return RESP_DECERR;
        if (size != SIZE_16B || burst == BURST_WRAP) return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    logic stall;

`ifdef AXI_MEM_SLAVE_STALL_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign stall = lfsr[0];
`else
    assign stall = 1'b0;
`endif

    logic unused;
    assign unused = ^{s_axi_arcache, s_axi_arlock, s_axi_arprot, s_axi_arqos,
                      s_axi_awcache, s_axi_awlock, s_axi_awprot, s_axi_awqos};

    // ------------------------------------------------------------------ read
    rd_state_t         rd_state;
    logic              arready_q;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_len;
    logic [7:0]        rd_cnt;
    logic [1:0]        rd_burst;
    logic [2:0]        rd_size;
    logic              rd_fetch_pend;
    logic              ar_hs;
    logic              r_hs;
    logic              rd_fetch;
    logic [DATA_W-1:0] ram_rd_data;

    assign s_axi_arready = arready_q & ~stall;
    assign ar_hs         = s_axi_arvalid & s_axi_arready;
    assign r_hs          = s_axi_rvalid & s_axi_rready;
    // A beat is fetched from RAM in the cycle before it is presented.
    assign rd_fetch      = (rd_state == R_DATA) & ~stall &
                           (rd_fetch_pend | (r_hs & ~s_axi_rlast));
    assign s_axi_rdata   = (s_axi_rvalid && s_axi_rresp == RESP_OKAY) ? ram_rd_data : '0;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state      <= R_IDLE;
            arready_q     <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rresp   <= RESP_OKAY;
            s_axi_rlast   <= 1'b0;
            s_axi_rid     <= '0;
            rd_addr       <= '0;
            rd_len        <= '0;
            rd_cnt        <= '0;
            rd_burst      <= '0;
            rd_size       <= '0;
            rd_fetch_pend <= 1'b0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (ar_hs) begin
                        arready_q     <= 1'b0;
                        rd_state      <= R_DATA;
                        s_axi_rid     <= s_axi_arid;
                        rd_addr       <= s_axi_araddr;
                        rd_len        <= s_axi_arlen;
                        rd_burst      <= s_axi_arburst;
                        rd_size       <= s_axi_arsize;
                        rd_cnt        <= '0;
                        rd_fetch_pend <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (rd_fetch) begin
                        s_axi_rvalid  <= 1'b1;
                        s_axi_rresp   <= beat_resp(rd_addr, rd_burst, rd_size);
                        s_axi_rlast   <= (rd_cnt == rd_len);
                        rd_cnt        <= rd_cnt + 8'd1;
                        rd_addr       <= next_addr(rd_addr, rd_burst);
                        rd_fetch_pend <= 1'b0;
                    end else if (r_hs) begin
                        s_axi_rvalid <= 1'b0;
                        if (s_axi_rlast) begin
                            s_axi_rlast <= 1'b0;
                            rd_state    <= R_IDLE;
                            arready_q   <= 1'b1;
                        end else begin
                            rd_fetch_pend <= 1'b1;
                        end
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    // ----------------------------------------------------------------- write
    wr_state_t         wr_state;
    logic              awready_q;
    logic              wready_q;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_len;
    logic [7:0]        wr_cnt;
    logic [1:0]        wr_burst;
    logic [2:0]        wr_size;
    logic              wr_over;
    logic              aw_hs;
    logic              w_hs;
    logic              b_hs;
    logic              wr_idx_match;
    logic [1:0]        wr_beat_resp;
    logic              ram_we;

    assign s_axi_awready = awready_q & ~stall;
    assign s_axi_wready  = wready_q & ~stall;
    assign aw_hs         = s_axi_awvalid & s_axi_awready;
    assign w_hs          = s_axi_wvalid & s_axi_wready;
    assign b_hs          = s_axi_bvalid & s_axi_bready;
    assign wr_idx_match  = ~wr_over & (wr_cnt == wr_len);

    // Beats past awlen are discarded; only a misplaced wlast can flag them.
    always_comb begin
        wr_beat_resp = wr_over ? RESP_OKAY : beat_resp(wr_addr, wr_burst, wr_size);
        if (s_axi_wlast && !wr_idx_match) begin
            wr_beat_resp = resp_worst(wr_beat_resp, RESP_SLVERR);
        end
    end

    assign ram_we = w_hs & ~wr_over & (wr_beat_resp == RESP_OKAY);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state     <= W_IDLE;
            awready_q    <= 1'b0;
            wready_q     <= 1'b0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
            s_axi_bid    <= '0;
            wr_addr      <= '0;
            wr_len       <= '0;
            wr_cnt       <= '0;
            wr_burst     <= '0;
            wr_size      <= '0;
            wr_over      <= 1'b0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (aw_hs) begin
                        awready_q   <= 1'b0;
                        wready_q    <= 1'b1;
                        wr_state    <= W_DATA;
                        s_axi_bid   <= s_axi_awid;
                        s_axi_bresp <= RESP_OKAY;
                        wr_addr     <= s_axi_awaddr;
                        wr_len      <= s_axi_awlen;
                        wr_burst    <= s_axi_awburst;
                        wr_size     <= s_axi_awsize;
                        wr_cnt      <= '0;
                        wr_over     <= 1'b0;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        s_axi_bresp <= resp_worst(s_axi_bresp, wr_beat_resp);
                        if (!wr_over) begin
                            wr_addr <= next_addr(wr_addr, wr_burst);
                            wr_cnt  <= wr_cnt + 8'd1;
                            if (wr_cnt == wr_len) begin
                                wr_over <= 1'b1;
                            end
                        end
                        if (s_axi_wlast) begin
                            wready_q     <= 1'b0;
                            wr_state     <= W_RESP;
                            s_axi_bvalid <= ~stall;
                        end
                    end
                end
                W_RESP: begin
                    if (!s_axi_bvalid && !stall) begin
                        s_axi_bvalid <= 1'b1;
                    end else if (b_hs) begin
                        s_axi_bvalid <= 1'b0;
                        wr_state     <= W_IDLE;
                        awready_q    <= 1'b1;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------ RAM
    axi_mem_ram #(
        .ADDR_BITS (MEM_DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .rd_en   (rd_fetch),
        .rd_addr (rd_addr[MEM_DEPTH_LOG2+3:4]),
        .rd_data (ram_rd_data),
        .wr_en   (ram_we),
        .wr_addr (wr_addr[MEM_DEPTH_LOG2+3:4]),
        .wr_data (s_axi_wdata),
        .wr_strb (s_axi_wstrb)
    );

endmodule

`default_nettype wire

// File: doc/axi_mem_slave.md
AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

Interface
REQ-001 SHALL have parameter MEM_DEPTH_LOG2, default 10, log2 of the number of 128-bit memory words.
REQ-002 SHALL have ports:
- clk  in  1  sole clock.
- aresetn  in  1  asynchronous active-low reset.
- s_axi_ar{addr[27:0], burst[1:0], cache[3:0], id[3:0], len[7:0], lock, prot[2:0], qos[3:0], size[2:0], valid}  in; s_axi_arready out.
- s_axi_r{data[127:0], id[3:0], last, resp[1:0], valid}  out; s_axi_rready in.
- s_axi_aw{addr[27:0], burst, cache, id, len, lock, prot, qos, size, valid}  in, widths as AR; s_axi_awready out.
- s_axi_w{data[127:0], strb[15:0], last, valid}  in; s_axi_wready out.
- s_axi_b{id[3:0], resp[1:0], valid}  out; s_axi_bready in.
REQ-003 SHALL ignore cache, lock, prot and qos.

Function
REQ-004 Read FSM SHALL have states R_IDLE (arready=1) and R_DATA (arready=0).
REQ-005 On an AR handshake, SHALL latch id/addr/len/burst/size, enter R_DATA, and assert rvalid exactly 1 cycle later.
REQ-006 SHALL hold rdata/rresp/rlast/rid stable while rvalid=1 and rready=0.
REQ-007 SHALL assert rlast on beat index == len; after the last-beat handshake, SHALL return to R_IDLE with arready=1 on the next cycle.
REQ-008 Beat address: INCR adds 16 per beat; FIXED repeats the start address; word index = addr[MEM_DEPTH_LOG2+3:4]; addr[3:0] ignored.
REQ-009 Beats SHALL respond SLVERR (2'b10) with rdata=0 when size != 3'b100 or burst=WRAP (2'b10).
REQ-010 Beats SHALL respond DECERR (2'b11) with rdata=0 when addr[27:MEM_DEPTH_LOG2+4] != 0; otherwise OKAY.
REQ-011 Write FSM SHALL have states W_IDLE (awready=1), W_DATA (wready=1), W_RESP (bvalid=1).
REQ-012 AW handshake: W_IDLE->W_DATA. wlast handshake: W_DATA->W_RESP. B handshake: W_RESP->W_IDLE.
REQ-013 SHALL write only bytes with wstrb[i]=1; SHALL suppress writes for SLVERR/DECERR beats.
REQ-014 bresp SHALL be the worst beat response (DECERR > SLVERR > OKAY); wlast on a beat index != awlen SHALL force SLVERR; beats after index awlen without wlast SHALL be accepted and discarded.
REQ-015 bid SHALL equal the latched awid; rid SHALL equal the latched arid.
REQ-016 Read and write channels SHALL run concurrently, each with one outstanding burst; a same-word read and write in the same cycle SHALL return old data.
REQ-017 Beat counters SHALL be 8-bit; the INCR address SHALL wrap modulo 2^28.

Reset
REQ-018 While aresetn=0, all outputs SHALL be 0 and both FSMs idle; arready/awready SHALL rise on the first clk edge after release.
REQ-019 Reset mid-burst SHALL abandon the burst without a response; memory contents SHALL be preserved.

Configuration
REQ-020 With AXI_MEM_SLAVE_STALL_EN defined, an 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5, advancing every cycle) SHALL gate arready, awready, wready and new rvalid/bvalid assertion (stall when bit0=1).
REQ-021 A stall SHALL never drop an asserted rvalid/bvalid.
REQ-022 Without AXI_MEM_SLAVE_STALL_EN, there SHALL be no stalls and no LFSR.

Structure
REQ-023 Package axi_mem_pkg SHALL hold the RESP_* and BURST_* constants, the read/write state enums, and the ADDR_W=28, DATA_W=128, ID_W=4 constants.
REQ-024 Storage SHALL be sub-module axi_mem_ram: 1 read port and 1 byte-enabled write port, synchronous read.

Verification
REQ-025 AR addr=0x100, len=3, INCR, size=4, rready=1 -> 4 beats, first beat 1 cycle after handshake, rlast on the 4th beat, rresp=OKAY, rid=arid.
REQ-026 AW addr=0x200, id=5, len=0, wdata=0x..AA, wstrb=16'h0001, then read 0x200 -> byte0=0xAA, other bytes unchanged, bid=5, bresp=OKAY.
REQ-027 AR addr=0xFFF_FFF0 (depth 10) -> rresp=DECERR, rdata=0; AR with burst=WRAP -> SLVERR.
REQ-028 AW len=3 with wlast on beat 1 -> bresp=SLVERR, FSM returns to W_IDLE.
REQ-029 rready held 0 for 5 cycles mid-burst -> rdata/rlast stable throughout, no beat lost.
REQ-030 aresetn pulsed low mid-read burst -> rvalid=0 immediately; after release, arready=1 and a new burst completes normally.
